// File: rtl/mem_stage.sv
// mem_stage: memory-access stage of the five-stage pipeline.
// Holds the EX/MEM pipeline register, runs a req/ack data-memory port with
// byte lanes and load extension, stalls upstream while an access is
// outstanding, and presents write-back controls/data to the WB stage.
// Optional feature macro: MEM_MISALIGN_TRAP_EN (adds the misalign output and
// refuses to issue misaligned half/word accesses).
module mem_stage #(
    parameter int TIMEOUT_CYCLES = 15,
    parameter int CNT_W          = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MemWr,
    input  logic        MemtoReg,
    input  logic        RegWr,
    input  logic        Branch,
    input  logic        Zero,
    input  logic        Jump,
    input  logic        Jal,
    input  logic        Loadext,
    input  logic [1:0]  Dsize,
    input  logic [1:0]  FPoint,
    input  logic [31:0] ALUout,
    input  logic [31:0] BusB,
    input  logic [31:0] BranchTarget,
    input  logic [31:0] Delayslot2,
    input  logic [4:0]  Rw,
    output logic        stall,
    output logic        PCSrc,
    output logic [31:0] pc_target,
    output logic        m_Jump,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        wb_RegWr,
    output logic        wb_MemtoReg,
    output logic        wb_Jal,
    output logic [4:0]  wb_Rw,
    output logic [1:0]  wb_FPoint,
    output logic [31:0] wb_ALUout,
    output logic [31:0] wb_MemData,
    output logic [31:0] wb_Delayslot2,
`ifdef MEM_MISALIGN_TRAP_EN
    output logic        misalign,
`endif
    output logic        bus_err
);

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_ACCESS = 1'b1;

    // Last ACCESS cycle count before the access is abandoned.
    localparam logic [CNT_W-1:0] TERM = CNT_W'(TIMEOUT_CYCLES - 1);

    // Byte enables for a store/load of the given size at low address bits a.
    function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] a);
        logic [3:0] be;
        case (size)
            2'b01:   be = a[1] ? 4'b1100 : 4'b0011;
            2'b10:   be = 4'b0001 << a;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Store data replicated across every lane so the enables pick the target.
    function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] b);
        logic [31:0] d;
        case (size)
            2'b01:   d = {2{b[15:0]}};
            2'b10:   d = {4{b[7:0]}};
            default: d = b;
        endcase
        return d;
    endfunction

    // Extract the addressed lane from read data and sign/zero extend it.
    function automatic logic [31:0] load_extract(input logic [1:0]  size,
                                                 input logic [1:0]  a,
                                                 input logic        sext,
                                                 input logic [31:0] rd);
        logic [31:0] r;
        logic [15:0] h;
        logic [7:0]  b;
        h = a[1] ? rd[31:16] : rd[15:0];
        case (a)
            2'b00:   b = rd[7:0];
            2'b01:   b = rd[15:8];
            2'b10:   b = rd[23:16];
            default: b = rd[31:24];
        endcase
        case (size)
            2'b01:   r = {{16{sext & h[15]}}, h};
            2'b10:   r = {{24{sext & b[7]}}, b};
            default: r = rd;
        endcase
        return r;
    endfunction

    logic [0:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_MemWr, r_MemtoReg, r_RegWr, r_Branch, r_Zero;
    logic             r_Jump, r_Jal, r_Loadext;
    logic [1:0]       r_Dsize, r_FPoint;
    logic [31:0]      r_ALUout, r_BusB, r_BranchTarget, r_Delayslot2;
    logic [4:0]       r_Rw;
    logic [31:0]      r_mem_data;
    logic             r_bus_err;

    logic             w_access;
    logic             w_issue;
    logic             w_suppress;
    logic             w_timeout;

    assign w_access  = (r_state == S_ACCESS);
    assign w_timeout = w_access & ~dmem_ack & (r_cnt == TERM);

`ifdef MEM_MISALIGN_TRAP_EN
    logic r_misalign;
    logic w_misaligned;
    assign w_misaligned = (MemWr | MemtoReg) &
                          (((Dsize == 2'b01) & ALUout[0]) |
                           (((Dsize == 2'b00) | (Dsize == 2'b11)) & (ALUout[1:0] != 2'b00)));
    assign w_suppress   = w_misaligned;
    assign misalign     = r_misalign;

    // One-cycle misalign pulse for a refused access captured in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_misalign <= 1'b0;
        end else begin
            r_misalign <= (r_state == S_IDLE) & w_misaligned;
        end
    end
`else
    assign w_suppress = 1'b0;
`endif

    assign w_issue = (MemWr | MemtoReg) & ~w_suppress;

    // EX/MEM pipeline register: capture when not stalled, kill writeback on timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_MemWr        <= 1'b0;
            r_MemtoReg     <= 1'b0;
            r_RegWr        <= 1'b0;
            r_Branch       <= 1'b0;
            r_Zero         <= 1'b0;
            r_Jump         <= 1'b0;
            r_Jal          <= 1'b0;
            r_Loadext      <= 1'b0;
            r_Dsize        <= 2'b00;
            r_FPoint       <= 2'b00;
            r_ALUout       <= 32'h0000_0000;
            r_BusB         <= 32'h0000_0000;
            r_BranchTarget <= 32'h0000_0000;
            r_Delayslot2   <= 32'h0000_0000;
            r_Rw           <= 5'd0;
        end else if (r_state == S_IDLE) begin
            r_MemWr        <= MemWr;
            r_MemtoReg     <= MemtoReg & ~w_suppress;
            r_RegWr        <= RegWr & ~w_suppress;
            r_Branch       <= Branch;
            r_Zero         <= Zero;
            r_Jump         <= Jump;
            r_Jal          <= Jal;
            r_Loadext      <= Loadext;
            r_Dsize        <= Dsize;
            r_FPoint       <= FPoint;
            r_ALUout       <= ALUout;
            r_BusB         <= BusB;
            r_BranchTarget <= BranchTarget;
            r_Delayslot2   <= Delayslot2;
            r_Rw           <= Rw;
        end else if (w_timeout) begin
            r_RegWr        <= 1'b0;
            r_MemtoReg     <= 1'b0;
        end
    end

    // Access FSM with timeout counter, load-data latch and bus error pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_mem_data <= 32'h0000_0000;
            r_bus_err  <= 1'b0;
        end else begin
            r_bus_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_issue) begin
                        r_state <= S_ACCESS;
                        r_cnt   <= '0;
                    end
                end
                S_ACCESS: begin
                    if (dmem_ack) begin
                        r_state    <= S_IDLE;
                        r_mem_data <= load_extract(r_Dsize, r_ALUout[1:0], r_Loadext, dmem_rdata);
                    end else if (w_timeout) begin
                        r_state   <= S_IDLE;
                        r_bus_err <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Memory port is quiet outside ACCESS so reset shows all-zero outputs.
    assign stall      = w_access;
    assign dmem_req   = w_access;
    assign dmem_we    = w_access & r_MemWr;
    assign dmem_addr  = w_access ? {r_ALUout[31:2], 2'b00} : 32'h0000_0000;
    assign dmem_wdata = w_access ? store_data(r_Dsize, r_BusB) : 32'h0000_0000;
    assign dmem_be    = w_access ? lane_be(r_Dsize, r_ALUout[1:0]) : 4'b0000;

    assign PCSrc      = r_Branch & r_Zero;
    assign pc_target  = r_BranchTarget;
    assign m_Jump     = r_Jump;
    assign bus_err    = r_bus_err;

    assign wb_RegWr      = r_RegWr & ~w_access;
    assign wb_MemtoReg   = r_MemtoReg;
    assign wb_Jal        = r_Jal;
    assign wb_Rw         = r_Rw;
    assign wb_FPoint     = r_FPoint;
    assign wb_ALUout     = r_ALUout;
    assign wb_MemData    = r_mem_data;
    assign wb_Delayslot2 = r_Delayslot2;

endmodule
